// File: rtl/ysyx_23060111_wbu_pkg.sv
// Shared definitions for the write-back path: FSM state encoding and load funct3 codes.
// The LSU and decoder use the same constants.
package ysyx_23060111_wbu_pkg;

  typedef enum logic [1:0] {
    WBU_IDLE     = 2'd0,
    WBU_WAIT_MEM = 2'd1,
    WBU_COMMIT   = 2'd2
  } wbu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/ysyx_23060111_ldfmt.sv
// Load data formatter. It picks the addressed byte or halfword from an aligned word,
// applies sign or zero extension, and flags misaligned or unknown-width loads.
module ysyx_23060111_ldfmt
  import ysyx_23060111_wbu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    unique case (addr_lo)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    err  = 1'b0;
    unique case (funct3)
      F3_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU: data = {24'd0, sel_byte};
      F3_LH: begin
        data = {{16{sel_half[15]}}, sel_half};
        err  = addr_lo[0];
      end
      F3_LHU: begin
        data = {16'd0, sel_half};
        err  = addr_lo[0];
      end
      F3_LW:  err = (addr_lo != 2'd0);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_23060111_wbu.sv
// Write-back unit: accepts one retired instruction, performs the load read if needed,
// then writes the register file and signals commit for one cycle.
module ysyx_23060111_wbu
  import ysyx_23060111_wbu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  mem_ren,
  output logic [DATA_WIDTH-1:0] mem_raddr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit,
  output logic [DATA_WIDTH-1:0] commit_pc,
  output logic                  load_err
);

  wbu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  mem_ren_q, mem_ren_d;

  logic [DATA_WIDTH-1:0] fmt_data;
  logic                  fmt_err;

  ysyx_23060111_ldfmt u_ldfmt (
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .rdata   (mem_rdata),
    .data    (fmt_data),
    .err     (fmt_err)
  );

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    pc_d      = pc_q;
    data_d    = data_q;
    err_d     = err_q;
    mem_ren_d = 1'b0;
    unique case (state_q)
      WBU_IDLE: begin
        if (in_valid) begin
          rd_d      = in_rd;
          funct3_d  = in_funct3;
          addr_d    = in_result;
          pc_d      = in_pc;
          data_d    = in_result;
          err_d     = 1'b0;
          mem_ren_d = in_is_load;
          state_d   = in_is_load ? WBU_WAIT_MEM : WBU_COMMIT;
        end
      end
      WBU_WAIT_MEM: begin
        // Errored loads still wait for the read so the memory side stays in step.
        if (mem_rvalid) begin
          data_d  = fmt_data;
          err_d   = fmt_err;
          state_d = WBU_COMMIT;
        end
      end
      WBU_COMMIT: state_d = WBU_IDLE;
      default:    state_d = WBU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WBU_IDLE;
      rd_q      <= '0;
      funct3_q  <= '0;
      addr_q    <= '0;
      pc_q      <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      mem_ren_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      pc_q      <= pc_d;
      data_q    <= data_d;
      err_q     <= err_d;
      mem_ren_q <= mem_ren_d;
    end
  end

  assign in_ready  = (state_q == WBU_IDLE);
  assign mem_ren   = mem_ren_q;
  assign mem_raddr = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign commit    = (state_q == WBU_COMMIT);
  assign load_err  = commit && err_q;
  assign rf_wen    = commit && !err_q && (rd_q != '0);
  assign rf_waddr  = rd_q;
  assign rf_wdata  = data_q;
  assign commit_pc = pc_q;

endmodule

// File: tb/tb_ysyx_23060111_wbu.sv
// Directed bench for the write-back unit: ALU writes, x0 suppression, load formatting,
// memory stalls, load errors and reset abort.
module tb_ysyx_23060111_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic [31:0] in_pc;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit;
  logic [31:0] commit_pc;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060111_wbu dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_is_load (in_is_load),
    .in_funct3  (in_funct3),
    .in_result  (in_result),
    .in_pc      (in_pc),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .commit     (commit),
    .commit_pc  (commit_pc),
    .load_err   (load_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".mem_ren"},  {31'd0, mem_ren},  32'd0);
    chk({tag, ".rf_wen"},   {31'd0, rf_wen},   32'd0);
    chk({tag, ".commit"},   {31'd0, commit},   32'd0);
    chk({tag, ".load_err"}, {31'd0, load_err}, 32'd0);
  endtask

  task automatic alu_op(input string tag, input logic [4:0] rd, input logic [31:0] res,
                        input logic [31:0] pc, input logic exp_wen);
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_result = res; in_pc = pc;
    in_funct3 = 3'b000;
    tick();
    in_valid = 1'b0;
    chk({tag, ".commit"},    {31'd0, commit},   32'd1);
    chk({tag, ".rf_wen"},    {31'd0, rf_wen},   {31'd0, exp_wen});
    chk({tag, ".load_err"},  {31'd0, load_err}, 32'd0);
    chk({tag, ".in_ready"},  {31'd0, in_ready}, 32'd0);
    chk({tag, ".commit_pc"}, commit_pc, pc);
    if (exp_wen) begin
      chk({tag, ".waddr"}, {27'd0, rf_waddr}, {27'd0, rd});
      chk({tag, ".wdata"}, rf_wdata, res);
    end
    tick();
    chk({tag, ".ready_again"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".commit_off"},  {31'd0, commit},   32'd0);
    $display("ALU %s rd=%0d res=%h pc=%h", tag, rd, res, pc);
  endtask

  task automatic load_op(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] word, input int delay,
                         input logic exp_err, input logic [31:0] exp_data);
    logic [31:0] pc;
    pc = 32'h8000_1000 + {addr[7:0], 4'h0};
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_funct3 = f3; in_result = addr;
    in_pc = pc; mem_rvalid = 1'b0;
    tick();
    in_valid = 1'b0;
    chk({tag, ".mem_ren"},   {31'd0, mem_ren},  32'd1);
    chk({tag, ".mem_raddr"}, mem_raddr, {addr[31:2], 2'b00});
    chk({tag, ".in_ready"},  {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk({tag, ".stall_ren"},   {31'd0, mem_ren},  32'd0);
      chk({tag, ".stall_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, ".stall_wen"},   {31'd0, rf_wen},   32'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = word;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    chk({tag, ".commit"},    {31'd0, commit},   32'd1);
    chk({tag, ".commit_pc"}, commit_pc, pc);
    chk({tag, ".load_err"},  {31'd0, load_err}, {31'd0, exp_err});
    chk({tag, ".rf_wen"},    {31'd0, rf_wen},   {31'd0, !exp_err});
    chk({tag, ".mem_ren"},   {31'd0, mem_ren},  32'd0);
    if (!exp_err) begin
      chk({tag, ".waddr"}, {27'd0, rf_waddr}, {27'd0, rd});
      chk({tag, ".wdata"}, rf_wdata, exp_data);
    end
    tick();
    chk({tag, ".ready_again"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".wen_off"},     {31'd0, rf_wen},   32'd0);
    $display("LOAD %s f3=%b addr=%h delay=%0d err=%0d data=%h", tag, f3, addr, delay,
             load_err, rf_wdata);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_is_load = 1'b0; in_funct3 = '0;
    in_result = '0; in_pc = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    chk_idle_outputs("reset");
    chk("reset.mem_raddr", mem_raddr, 32'd0);
    chk("reset.commit_pc", commit_pc, 32'd0);
    chk("reset.rf_wdata",  rf_wdata,  32'd0);
    $display("RESET released");
    rst = 1'b0;
    tick();

    alu_op("alu_rd5", 5'd5, 32'h1234_5678, 32'h8000_0000, 1'b1);
    alu_op("alu_x0",  5'd0, 32'hCAFE_0001, 32'h8000_0004, 1'b0);
    alu_op("alu_rd31", 5'd31, 32'hFFFF_FFFF, 32'h8000_0008, 1'b1);

    load_op("lb_p1",  5'd7,  3'b000, 32'h8000_0081, 32'hF0E1_D2C3, 0, 1'b0, 32'hFFFF_FFD2);
    load_op("lbu_p3", 5'd8,  3'b100, 32'h8000_0083, 32'hF0E1_D2C3, 0, 1'b0, 32'h0000_00F0);
    load_op("lh_p2",  5'd9,  3'b001, 32'h8000_0082, 32'hF0E1_D2C3, 1, 1'b0, 32'hFFFF_F0E1);
    load_op("lhu_p2", 5'd10, 3'b101, 32'h8000_0082, 32'hF0E1_D2C3, 0, 1'b0, 32'h0000_F0E1);
    load_op("lb_p0",  5'd11, 3'b000, 32'h8000_0080, 32'hF0E1_D2C3, 0, 1'b0, 32'hFFFF_FFC3);
    load_op("lw_stall", 5'd12, 3'b010, 32'h8000_0084, 32'h1122_3344, 5, 1'b0, 32'h1122_3344);
    load_op("lw_misal", 5'd13, 3'b010, 32'h8000_0082, 32'hF0E1_D2C3, 0, 1'b1, 32'h0);
    load_op("lh_odd",   5'd14, 3'b001, 32'h8000_0081, 32'hF0E1_D2C3, 0, 1'b1, 32'h0);
    load_op("f3_011",   5'd15, 3'b011, 32'h8000_0080, 32'hF0E1_D2C3, 0, 1'b1, 32'h0);

    // Reset while waiting for memory, then a stray rvalid afterwards.
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd3; in_funct3 = 3'b010;
    in_result = 32'h8000_0090; in_pc = 32'h8000_2000;
    tick();
    in_valid = 1'b0;
    chk("rstwait.mem_ren", {31'd0, mem_ren}, 32'd1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("rstwait.async");
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    chk_idle_outputs("rstwait.after");
    tick();
    chk_idle_outputs("rstwait.after2");
    chk("rstwait.mem_raddr", mem_raddr, 32'd0);
    chk("rstwait.commit_pc", commit_pc, 32'd0);
    $display("RESET in WAIT_MEM aborted load");

    alu_op("alu_post_rst", 5'd4, 32'h0BAD_F00D, 32'h8000_3000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
